// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter sharing one slave port between NUM_MASTERS requesters.
// Supports locked sequences and a per-owner beat quota that forces re-arbitration.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_HOLD    = 8,
  parameter int DEF_MASTER  = 0,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [MW-1:0] DEF_IDX  = MW'(DEF_MASTER);

  typedef enum logic [1:0] {PARK = 2'd0, OWNED = 2'd1, LOCKED = 2'd2} state_e;

  state_e                  state, state_n;
  logic [CW-1:0]           hold_cnt, cnt_n, cnt_inc;
  logic [MW-1:0]           rr_ptr, rr_n, master_n, win_idx, cand;
  logic [NUM_MASTERS-1:0]  grant_n;
  logic                    lock_n, win_found, arb, beat;

  assign dbg_state = state;
  assign beat      = HTRANS[1];

  // First requester after rr_ptr, wrapping so rr_ptr itself is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = MW'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (!win_found && HBUSREQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = hold_cnt;
    rr_n     = rr_ptr;
    master_n = HMASTER;
    arb      = 1'b0;
    cnt_inc  = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CW'(beat);
    unique case (state)
      PARK:   arb = |HBUSREQ;
      OWNED: begin
        if (!HBUSREQ[HMASTER])   arb = 1'b1;
        else if (HLOCK[HMASTER]) state_n = LOCKED;
        // Quota counts the beat accepted at this edge, so the owner gets exactly MAX_HOLD beats.
        else if (cnt_inc == HOLD_MAX) arb = 1'b1;
        else cnt_n = cnt_inc;
      end
      LOCKED: arb = !HLOCK[HMASTER] && (HTRANS == 2'b00);
      default: arb = 1'b1;
    endcase
    if (arb) begin
      cnt_n = '0;
      if (win_found) begin
        master_n = win_idx;
        rr_n     = win_idx;
        state_n  = (HLOCK[win_idx] && HBUSREQ[win_idx]) ? LOCKED : OWNED;
      end else begin
        master_n = DEF_IDX;
        state_n  = PARK;
      end
    end
    grant_n           = '0;
    grant_n[master_n] = 1'b1;
    lock_n            = HLOCK[master_n] & HBUSREQ[master_n];
  end

  // HREADY low freezes everything so the old owner's data phase completes untouched.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= PARK;
      hold_cnt  <= '0;
      rr_ptr    <= DEF_IDX;
      HGRANT    <= NUM_MASTERS'(1) << DEF_MASTER;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      state     <= state_n;
      hold_cnt  <= cnt_n;
      rr_ptr    <= rr_n;
      HGRANT    <= grant_n;
      HMASTER   <= master_n;
      HMASTER_D <= HMASTER;
      HMASTLOCK <= lock_n;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: directed scenarios plus random traffic, scored against a
// queue-based reference model of the arbitration rules.
module tb_ahb_bus_arbiter;
  localparam int N   = 3;
  localparam int MW  = 2;
  localparam int MH  = 8;
  localparam int DEF = 0;
  localparam int EW  = N + 2 * MW + 1;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [N-1:0]  HBUSREQ = '0;
  logic [N-1:0]  HLOCK = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic          HREADY = 1'b1;
  logic [N-1:0]  HGRANT;
  logic [MW-1:0] HMASTER, HMASTER_D;
  logic          HMASTLOCK;
  logic [1:0]    dbg_state;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH), .DEF_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_D(HMASTER_D),
    .HMASTLOCK(HMASTLOCK), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: owner index, parked flag, locked flag, beats used in current tenure
  int m_owner = DEF, m_rr = DEF, m_beats = 0, m_d = DEF;
  bit m_park = 1, m_locked = 0, m_mlock = 0;

  function automatic void model_step(input bit rst, input logic [N-1:0] req,
                                     input logic [N-1:0] lk, input logic [1:0] tr, input bit rdy);
    bit do_arb;
    int win;
    if (rst) begin
      m_owner = DEF; m_rr = DEF; m_beats = 0; m_d = DEF;
      m_park = 1; m_locked = 0; m_mlock = 0;
      return;
    end
    if (!rdy) return;
    m_d = m_owner;
    do_arb = 0;
    if (m_park) do_arb = (req != 0);
    else if (m_locked) do_arb = !lk[m_owner] && (tr == 2'b00);
    else if (!req[m_owner]) do_arb = 1;
    else if (lk[m_owner]) m_locked = 1;
    else begin
      if (tr[1]) m_beats++;
      if (m_beats >= MH) do_arb = 1;
    end
    if (do_arb) begin
      win = -1;
      for (int k = 1; k <= N; k++)
        if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
      m_beats = 0;
      if (win < 0) begin
        m_owner = DEF; m_park = 1; m_locked = 0;
      end else begin
        m_owner = win; m_rr = win; m_park = 0; m_locked = lk[win] & req[win];
      end
    end
    m_mlock = lk[m_owner] & req[m_owner];
  endfunction

  // driver: apply inputs at negedge, push the state expected after the next posedge
  task automatic step(input bit rst, input logic [N-1:0] req, input logic [N-1:0] lk,
                      input logic [1:0] tr, input bit rdy);
    logic [N-1:0] g;
    @(negedge HCLK);
    HRESET = rst; HBUSREQ = req; HLOCK = lk; HTRANS = tr; HREADY = rdy;
    model_step(rst, req, lk, tr, rdy);
    g = '0;
    g[m_owner] = 1'b1;
    exp_q.push_back({g, MW'(m_owner), MW'(m_d), m_mlock});
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge HCLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hgrant",    int'(HGRANT),    int'(e[EW-1 -: N]));
        check("hmaster",   int'(HMASTER),   int'(e[2*MW:MW+1]));
        check("hmaster_d", int'(HMASTER_D), int'(e[MW:1]));
        check("hmastlock", int'(HMASTLOCK), int'(e[0]));
        check("onehot",    int'($onehot(HGRANT)), 1);
      end
    end
  end

  initial begin
    logic [N-1:0] req, lk;
    // reset, then idle park for 10 cycles
    repeat (2) step(1, '0, '0, 2'b00, 1);
    repeat (10) step(0, '0, '0, 2'b00, 1);
    // single request from M1, NONSEQ beats
    repeat (4) step(0, 3'b010, '0, 2'b10, 1);
    // all request continuously: rotation with 8-beat quotas
    repeat (40) step(0, 3'b111, '0, 2'b10, 1);
    // M2 locked while others request, then unlock with IDLE
    step(1, '0, '0, 2'b00, 1);
    step(0, 3'b100, 3'b100, 2'b10, 1);
    repeat (20) step(0, 3'b111, 3'b100, 2'b10, 1);
    step(0, 3'b111, 3'b000, 2'b00, 1);
    repeat (3) step(0, 3'b111, 3'b000, 2'b10, 1);
    // M1 drops request while HREADY is low
    step(1, '0, '0, 2'b00, 1);
    repeat (3) step(0, 3'b010, '0, 2'b10, 1);
    repeat (3) step(0, 3'b000, '0, 2'b00, 0);
    repeat (2) step(0, 3'b000, '0, 2'b00, 1);
    // reset pulsed mid-burst, M1 then gets a fresh quota against competitors
    step(1, '0, '0, 2'b00, 1);
    repeat (6) step(0, 3'b010, '0, 2'b10, 1);
    step(1, 3'b010, '0, 2'b10, 1);
    repeat (12) step(0, 3'b111, '0, 2'b10, 1);
    // random traffic
    req = '0;
    lk = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) lk = N'($urandom_range(0, 7)) & req;
      step($urandom_range(0, 199) == 0, req, lk, 2'($urandom_range(0, 3)),
           $urandom_range(0, 4) != 0);
    end
    @(posedge HCLK);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
